// File: rtl/gpu_vga_pkg.sv
// Shared timing constants and types for the VGA raster generator.
// Defaults describe 800x600@60 with a 40 MHz pixel clock.
package gpu_vga_pkg;

  localparam int COORD_W = 10;
  localparam int HCNT_W  = 11;

  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT   = 40;
  localparam int DEF_H_SYNC    = 128;
  localparam int DEF_H_BACK    = 88;
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT   = 1;
  localparam int DEF_V_SYNC    = 4;
  localparam int DEF_V_BACK    = 23;

  localparam int DEF_H_TOTAL    = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL    = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_HSYNC_BEG  = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_HSYNC_END  = DEF_HSYNC_BEG + DEF_H_SYNC;
  localparam int DEF_VSYNC_BEG  = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_VSYNC_END  = DEF_VSYNC_BEG + DEF_V_SYNC;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_t;

  function automatic sync_t sync_idle(input logic pol);
    return '{hsync: ~pol, vsync: ~pol, blank: 1'b1};
  endfunction

endpackage

// File: rtl/gpu_sync_delay.sv
// Enable-gated shift register that delays hsync/vsync/blank so they stay
// aligned with the downstream layer pipeline.
module gpu_sync_delay
  import gpu_vga_pkg::*;
#(
  parameter int   DEPTH    = 1,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  sync_t din,
  output sync_t dout
);

  localparam sync_t IDLE = sync_idle(SYNC_POL);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst ^ en;
      assign dout = din;
    end else begin : g_pipe
      sync_t stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/gpu_vga_timing.sv
// Raster position and VGA sync generator; row/col feed the overlay layers,
// delayed sync/blank feed the DAC.
module gpu_vga_timing
  import gpu_vga_pkg::*;
#(
  parameter int   H_VISIBLE  = DEF_H_VISIBLE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_VISIBLE  = DEF_V_VISIBLE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic SYNC_POL   = 1'b1,
  parameter int   PIPE_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               active,
  output logic               frame_start,
  output logic               line_start,
  output logic               hsync,
  output logic               vsync,
  output logic               blank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HCNT_W-1:0]  H_VIS   = HCNT_W'(H_VISIBLE);
  localparam logic [HCNT_W-1:0]  H_LAST  = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0]  HS_BEG  = HCNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [HCNT_W-1:0]  HS_FIN  = HCNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] V_VIS   = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_FIN  = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  generate
    if (H_VISIBLE > 1023 || V_TOTAL > 1023 || PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_param_check
      $error("gpu_vga_timing: H_VISIBLE/V_TOTAL must fit 10 bits and PIPE_DELAY must be 0..4");
    end
  endgenerate

  logic [HCNT_W-1:0]  h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               vis;
  logic               h_zero;
  logic               v_zero;
  sync_t              raw;
  sync_t              dly;

  assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign h_zero = (h_cnt == '0);
  assign v_zero = (v_cnt == '0);

  // vsync is decoded from v_cnt only, so it can change just when the line wraps
  assign raw = '{
    hsync: ((h_cnt >= HS_BEG) && (h_cnt < HS_FIN)) ? SYNC_POL : ~SYNC_POL,
    vsync: ((v_cnt >= VS_BEG) && (v_cnt < VS_FIN)) ? SYNC_POL : ~SYNC_POL,
    blank: ~vis
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  gpu_sync_delay #(
    .DEPTH    (PIPE_DELAY),
    .SYNC_POL (SYNC_POL)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .din  (raw),
    .dout (dly)
  );

  // Outputs present the pre-edge position; pulses drop on disabled edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      blank       <= 1'b1;
    end else if (pix_en) begin
      row         <= vis ? v_cnt : '0;
      col         <= vis ? h_cnt[COORD_W-1:0] : '0;
      active      <= vis;
      frame_start <= h_zero && v_zero;
      line_start  <= h_zero;
      hsync       <= dly.hsync;
      vsync       <= dly.vsync;
      blank       <= dly.blank;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpu_vga_timing.sv
// Scoreboard bench: three timing configurations driven from one pix_en/rst,
// expected outputs queued by the stimulus and popped by a monitor.
module tb_gpu_vga_timing;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       act;
    logic       fs;
    logic       ls;
    logic       hs;
    logic       vs;
    logic       bl;
  } obs_t;

  typedef struct packed {
    obs_t d0;
    obs_t d1;
    obs_t d2;
  } exp_t;

  // instance 0: tiny, PD=0, pol 1; instance 1: tiny, PD=2, pol 0; instance 2: defaults
  localparam int   P_HV [3] = '{8, 8, 800};
  localparam int   P_HF [3] = '{2, 2, 40};
  localparam int   P_HS [3] = '{3, 3, 128};
  localparam int   P_HB [3] = '{2, 2, 88};
  localparam int   P_VV [3] = '{4, 4, 600};
  localparam int   P_VF [3] = '{1, 1, 1};
  localparam int   P_VS [3] = '{2, 2, 4};
  localparam int   P_VB [3] = '{1, 1, 23};
  localparam int   P_PD [3] = '{0, 2, 1};
  localparam logic P_POL[3] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst;
  logic pix_en;

  logic [9:0] a_row, a_col, b_row, b_col, c_row, c_col;
  logic a_act, a_fs, a_ls, a_hs, a_vs, a_bl;
  logic b_act, b_fs, b_ls, b_hs, b_vs, b_bl;
  logic c_act, c_fs, c_ls, c_hs, c_vs, c_bl;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  int         mh  [3];
  int         mv  [3];
  logic [2:0] hist[3][5];
  obs_t       mout[3];

  always #5 clk = ~clk;

  gpu_vga_timing #(
    .H_VISIBLE(P_HV[0]), .H_FRONT(P_HF[0]), .H_SYNC(P_HS[0]), .H_BACK(P_HB[0]),
    .V_VISIBLE(P_VV[0]), .V_FRONT(P_VF[0]), .V_SYNC(P_VS[0]), .V_BACK(P_VB[0]),
    .SYNC_POL(P_POL[0]), .PIPE_DELAY(P_PD[0])
  ) dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .row(a_row), .col(a_col), .active(a_act),
    .frame_start(a_fs), .line_start(a_ls), .hsync(a_hs), .vsync(a_vs), .blank(a_bl)
  );

  gpu_vga_timing #(
    .H_VISIBLE(P_HV[1]), .H_FRONT(P_HF[1]), .H_SYNC(P_HS[1]), .H_BACK(P_HB[1]),
    .V_VISIBLE(P_VV[1]), .V_FRONT(P_VF[1]), .V_SYNC(P_VS[1]), .V_BACK(P_VB[1]),
    .SYNC_POL(P_POL[1]), .PIPE_DELAY(P_PD[1])
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .row(b_row), .col(b_col), .active(b_act),
    .frame_start(b_fs), .line_start(b_ls), .hsync(b_hs), .vsync(b_vs), .blank(b_bl)
  );

  gpu_vga_timing dut_c (
    .clk(clk), .rst(rst), .pix_en(pix_en), .row(c_row), .col(c_col), .active(c_act),
    .frame_start(c_fs), .line_start(c_ls), .hsync(c_hs), .vsync(c_vs), .blank(c_bl)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic obs_t get_obs(input int i);
    case (i)
      0:       return {a_row, a_col, a_act, a_fs, a_ls, a_hs, a_vs, a_bl};
      1:       return {b_row, b_col, b_act, b_fs, b_ls, b_hs, b_vs, b_bl};
      default: return {c_row, c_col, c_act, c_fs, c_ls, c_hs, c_vs, c_bl};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0;
      mv[i] = 0;
      for (int k = 0; k < 5; k++) hist[i][k] = {~P_POL[i], ~P_POL[i], 1'b1};
      mout[i] = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, ~P_POL[i], ~P_POL[i], 1'b1};
    end
  endtask

  // Reference raster: outputs for the current position, then advance
  task automatic model_edge(input int i, input logic en);
    obs_t       o;
    logic       vis;
    logic [2:0] raw;
    logic [2:0] d;
    int         h, v, hs0, vs0;
    if (en) begin
      h   = mh[i];
      v   = mv[i];
      hs0 = P_HV[i] + P_HF[i];
      vs0 = P_VV[i] + P_VF[i];
      vis = (h < P_HV[i]) && (v < P_VV[i]);
      o.row = vis ? 10'(v) : 10'd0;
      o.col = vis ? 10'(h) : 10'd0;
      o.act = vis;
      o.fs  = (h == 0) && (v == 0);
      o.ls  = (h == 0);
      raw[2] = (h >= hs0 && h < hs0 + P_HS[i]) ? P_POL[i] : ~P_POL[i];
      raw[1] = (v >= vs0 && v < vs0 + P_VS[i]) ? P_POL[i] : ~P_POL[i];
      raw[0] = ~vis;
      d = (P_PD[i] == 0) ? raw : hist[i][P_PD[i]-1];
      for (int k = 4; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = raw;
      {o.hs, o.vs, o.bl} = d;
      mout[i] = o;
      if (h == P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i] - 1) begin
        mh[i] = 0;
        mv[i] = (v == P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i] - 1) ? 0 : v + 1;
      end else begin
        mh[i] = h + 1;
      end
    end else begin
      mout[i].fs = 1'b0;
      mout[i].ls = 1'b0;
    end
  endtask

  task automatic step(input logic en);
    @(negedge clk);
    #1;
    pix_en = en;
    for (int i = 0; i < 3; i++) model_edge(i, en);
    exp_q.push_back({mout[0], mout[1], mout[2]});
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, "_a"}, 32'(get_obs(0)), 32'(mout[0]));
    chk({tag, "_b"}, 32'(get_obs(1)), 32'(mout[1]));
    chk({tag, "_c"}, 32'(get_obs(2)), 32'(mout[2]));
  endtask

  // Scoreboard monitor: one queued expectation per clk edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scb_a", 32'(get_obs(0)), 32'(e.d0));
      chk("scb_b", 32'(get_obs(1)), 32'(e.d1));
      chk("scb_c", 32'(get_obs(2)), 32'(e.d2));
    end
  end

  // Hand-computed interval checks, counted in enabled edges
  logic en_q = 1'b0;
  logic fs_seen = 1'b0;
  int   fs_gap = 0;
  int   hrun   = 0;
  int   vrun   = 0;

  always @(posedge clk) en_q <= pix_en;

  always @(negedge clk) begin
    if (rst) begin
      fs_seen <= 1'b0;
      fs_gap  <= 0;
      hrun    <= 0;
      vrun    <= 0;
    end else if (en_q) begin
      if (a_fs) begin
        if (fs_seen) chk("frame_period_a", 32'(fs_gap), 32'd120);
        fs_seen <= 1'b1;
        fs_gap  <= 1;
      end else begin
        fs_gap <= fs_gap + 1;
      end
      if (c_hs) begin
        hrun <= hrun + 1;
      end else begin
        if (hrun != 0) chk("hsync_width_c", 32'(hrun), 32'd128);
        hrun <= 0;
      end
      if (a_vs) begin
        vrun <= vrun + 1;
      end else begin
        if (vrun != 0) chk("vsync_width_a", 32'(vrun), 32'd30);
        vrun <= 0;
      end
    end
  end

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #2;
    check_reset_now("reset_state");
    @(negedge clk);
    #1;
    rst = 1'b0;

    repeat (1070) step(1'b1);
    for (int k = 0; k < 20; k++) step((k % 2) == 0);
    repeat (20) step(1'b0);
    repeat (37) step(1'b1);

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    #1;
    rst    = 1'b1;
    pix_en = 1'b1;
    #1;
    model_reset();
    check_reset_now("async_reset");
    @(negedge clk);
    #1;
    rst    = 1'b0;
    pix_en = 1'b0;

    repeat (200) step(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
